// File: rtl/alu_disp_pkg.sv
// Shared definitions for the ALU result display: operation encodings and the
// hex-to-segment glyph table ({a,b,c,d,e,f,g}, seg[6]=a, active-high).
package alu_disp_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  // Index 15 (F) first, index 0 last.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to 7-segment glyph lookup.
module hex_to_7seg
  import alu_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPHS[nibble];

endmodule

// File: rtl/alu_scan_7seg.sv
// ALU with captured result shown on a time-multiplexed hex 7-segment display.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module alu_scan_7seg
  import alu_disp_pkg::*;
#(
  parameter int N        = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         A,
  input  logic [N-1:0]         B,
  input  logic [1:0]           OP,
  input  logic                 load,
  input  logic                 enable,
  output logic [6:0]           seg,
  output logic [(N/4)-1:0]     an,
  output logic                 cout
);

  localparam int DIGITS = N / 4;
  localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW     = $clog2(SCAN_DIV);

  logic [N:0]    alu_s;
  logic [N-1:0]  result_r;
  logic [CW-1:0] div_r;
  logic [DW-1:0] dig_r;
  logic          div_last_s;
  logic [3:0]    nib_s;
  logic [6:0]    glyph_s;
  logic          blank_s;

  // ALU in N+1 bits; bit N is the add carry or the subtract borrow
  always_comb begin
    alu_s = '0;
    case (alu_op_e'(OP))
      OP_ADD:  alu_s = {1'b0, A} + {1'b0, B};
      OP_SUB:  alu_s = {1'b0, A} - {1'b0, B};
      OP_AND:  alu_s = {1'b0, A & B};
      OP_OR:   alu_s = {1'b0, A | B};
      default: alu_s = '0;
    endcase
  end

  // Result capture on load
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= '0;
      cout     <= 1'b0;
    end else if (load) begin
      result_r <= alu_s[N-1:0];
      cout     <= alu_s[N];
    end else begin
      result_r <= result_r;
      cout     <= cout;
    end
  end

  assign div_last_s = (div_r == CW'(SCAN_DIV - 1));

  // Scan divider and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= '0;
      dig_r <= '0;
    end else if (div_last_s) begin
      div_r <= '0;
      dig_r <= (dig_r == DW'(DIGITS - 1)) ? '0 : dig_r + DW'(1);
    end else begin
      div_r <= div_r + CW'(1);
      dig_r <= dig_r;
    end
  end

  assign nib_s = 4'(result_r >> {dig_r, 2'b00});

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_s = (dig_r != '0) && ((result_r >> {dig_r, 2'b00}) == '0);
`else
  assign blank_s = 1'b0;
`endif

  hex_to_7seg u_hex (
    .nibble (nib_s),
    .seg    (glyph_s)
  );

  // Output register, gated by enable and leading-zero blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= '0;
    end else if (enable && !blank_s) begin
      seg <= glyph_s;
      an  <= DIGITS'(1'b1) << dig_r;
    end else begin
      seg <= SEG_BLANK;
      an  <= '0;
    end
  end

endmodule

// File: tb/tb_alu_scan_7seg.sv
// Randomized self-checking bench for alu_scan_7seg (N=16, short scan period)
// against a cycle-count based reference model.
module tb_alu_scan_7seg;

  localparam int N     = 16;
  localparam int SD    = 4;
  localparam int DIG   = N / 4;
  localparam int FRAME = DIG * SD;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, load, enable;
  logic [N-1:0]   A, B;
  logic [1:0]     OP;
  logic [6:0]     seg;
  logic [DIG-1:0] an;
  logic           cout;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int unsigned    t_m    = 0;
  logic [N-1:0]   res_m  = '0;
  logic           cout_m = 1'b0;
  logic [6:0]     seg_m  = 7'h00;
  logic [DIG-1:0] an_m   = '0;
  int             d_m;
  int             sum_m;

  alu_scan_7seg #(.N(N), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .OP(OP), .load(load),
    .enable(enable), .seg(seg), .an(an), .cout(cout)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    string s;
    logic [6:0] g;
    int c;
    g = 7'h00;
    case (v)
      4'h0: s = "abcdef";  4'h1: s = "bc";      4'h2: s = "abdeg";  4'h3: s = "abcdg";
      4'h4: s = "bcfg";    4'h5: s = "acdfg";   4'h6: s = "acdefg"; 4'h7: s = "abc";
      4'h8: s = "abcdefg"; 4'h9: s = "abcdfg";  4'hA: s = "abcefg"; 4'hB: s = "cdefg";
      4'hC: s = "adef";    4'hD: s = "bcdeg";   4'hE: s = "adefg";  default: s = "aefg";
    endcase
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      g[6 - (c - 97)] = 1'b1;
    end
    return g;
  endfunction

  // Model: digit shown is (edges since reset / SD) mod DIG, output one edge late
  always @(posedge clk) begin
    if (rst) begin
      t_m = 0; res_m = '0; cout_m = 1'b0; seg_m = 7'h00; an_m = '0;
    end else begin
      d_m = (t_m / SD) % DIG;
      if (enable && !(LZB && d_m > 0 && int'(res_m) < (1 << (4 * d_m)))) begin
        an_m  = DIG'(1 << d_m);
        seg_m = glyph(4'(res_m >> (4 * d_m)));
      end else begin
        an_m  = '0;
        seg_m = 7'h00;
      end
      if (load) begin
        case (OP)
          2'd0: begin sum_m = int'(A) + int'(B); res_m = N'(sum_m); cout_m = (sum_m >= (1 << N)); end
          2'd1: begin res_m = A - B; cout_m = (A < B); end
          2'd2: begin res_m = A & B; cout_m = 1'b0; end
          default: begin res_m = A | B; cout_m = 1'b0; end
        endcase
      end
      t_m++;
    end
  end

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; load = 1'b0; A = '0; B = '0; OP = 2'd0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (seg !== 7'h00 || an !== 4'b0000 || cout !== 1'b0) begin
        miscompares++;
        $display("FAIL reset: seg=%h an=%b cout=%b, want 00 0000 0", seg, an, cout);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (an !== 4'b0001 || seg !== 7'h7E) begin
      miscompares++;
      $display("FAIL reset_release: an=%b seg=%h, want 0001 7e", an, seg);
    end
  endtask

  task automatic test_add();
    int n5, n1;
    n5 = 0; n1 = 0;
    A = 16'hFFF0; B = 16'h0025; OP = 2'd0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    vectors++;
    if (cout !== 1'b1) begin
      miscompares++;
      $display("FAIL add_cout: cout=%b, want 1", cout);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      vectors++;
      if (seg !== seg_m || an !== an_m || cout !== cout_m) begin
        miscompares++;
        $display("FAIL add cyc%0d: seg=%h an=%b cout=%b, want %h %b %b", i, seg, an, cout, seg_m, an_m, cout_m);
      end
      if (an === 4'b0001 && seg === 7'h5B) n5++;
      if (an === 4'b0010 && seg === 7'h30) n1++;
    end
    vectors++;
    if (n5 != 2 * SD || n1 != 2 * SD) begin
      miscompares++;
      $display("FAIL add_digits: digit0 '5' cycles=%0d digit1 '1' cycles=%0d, want %0d each", n5, n1, 2 * SD);
    end
  endtask

  task automatic test_sub();
    int ne;
    ne = 0;
    A = 16'h0003; B = 16'h0005; OP = 2'd1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    vectors++;
    if (cout !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_borrow: cout=%b, want 1", cout);
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      vectors++;
      if (seg !== seg_m || an !== an_m || cout !== cout_m) begin
        miscompares++;
        $display("FAIL sub cyc%0d: seg=%h an=%b cout=%b, want %h %b %b", i, seg, an, cout, seg_m, an_m, cout_m);
      end
      if (an === 4'b0001 && seg === 7'h4F) ne++;
    end
    vectors++;
    if (ne != SD) begin
      miscompares++;
      $display("FAIL sub_digitE: cycles=%0d, want %0d", ne, SD);
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vectors++;
      if ((i > 0 && (seg !== 7'h00 || an !== 4'b0000)) || seg !== seg_m || an !== an_m) begin
        miscompares++;
        $display("FAIL enable_off cyc%0d: seg=%h an=%b, want %h %b", i, seg, an, seg_m, an_m);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < FRAME + 2; i++) begin
      @(negedge clk);
      vectors++;
      if (seg !== seg_m || an !== an_m) begin
        miscompares++;
        $display("FAIL enable_on cyc%0d: seg=%h an=%b, want %h %b", i, seg, an, seg_m, an_m);
      end
    end
  endtask

  task automatic test_load_at_advance();
    int guard;
    int nd;
    guard = 0;
    while ((t_m % SD) != SD - 1 && guard < FRAME) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if ((t_m % SD) != SD - 1) begin
      miscompares++;
      $display("FAIL advance_wait: phase=%0d, want %0d", t_m % SD, SD - 1);
    end
    nd = ((t_m + 1) / SD) % DIG;
    A = 16'h0A0B; B = 16'h0100; OP = 2'd3; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    vectors++;
    if (an !== DIG'(1 << nd) || seg !== glyph(4'(16'h0B0B >> (4 * nd)))) begin
      if (!(LZB && nd == 3 && an === 4'b0000 && seg === 7'h00)) begin
        miscompares++;
        $display("FAIL load_advance: an=%b seg=%h, want digit %0d of 0b0b", an, seg, nd);
      end
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      vectors++;
      if (seg !== seg_m || an !== an_m || cout !== cout_m) begin
        miscompares++;
        $display("FAIL advance cyc%0d: seg=%h an=%b cout=%b, want %h %b %b", i, seg, an, cout, seg_m, an_m, cout_m);
      end
    end
  endtask

  task automatic test_reset_midscan();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (seg !== 7'h00 || an !== 4'b0000 || cout !== 1'b0) begin
      miscompares++;
      $display("FAIL midscan_reset: seg=%h an=%b cout=%b, want 00 0000 0", seg, an, cout);
    end
    rst = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      vectors++;
      if (seg !== seg_m || an !== an_m || (i == 0 && an !== 4'b0001)) begin
        miscompares++;
        $display("FAIL midscan cyc%0d: seg=%h an=%b, want %h %b", i, seg, an, seg_m, an_m);
      end
    end
  endtask

  task automatic test_leading_blank();
    int n7, nhi;
    n7 = 0; nhi = 0;
    A = 16'h0003; B = 16'h0004; OP = 2'd0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      vectors++;
      if (seg !== seg_m || an !== an_m) begin
        miscompares++;
        $display("FAIL blank cyc%0d: seg=%h an=%b, want %h %b", i, seg, an, seg_m, an_m);
      end
      if (an === 4'b0001 && seg === 7'h70) n7++;
      if (an[3:1] !== 3'b000) nhi++;
    end
    vectors++;
    if (n7 != SD || nhi != (LZB ? 0 : FRAME - SD)) begin
      miscompares++;
      $display("FAIL blank_slots: '7' cycles=%0d upper cycles=%0d, want %0d %0d", n7, nhi, SD, LZB ? 0 : FRAME - SD);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      A = N'($urandom); B = N'($urandom); OP = 2'($urandom_range(0, 3));
      if (k % 5 == 0) A = A & 16'h00FF;
      enable = ($urandom_range(0, 7) != 0);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      A = N'($urandom); B = N'($urandom);
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
        @(negedge clk);
        vectors++;
        if (seg !== seg_m || an !== an_m || cout !== cout_m) begin
          miscompares++;
          $display("FAIL random k%0d cyc%0d: seg=%h an=%b cout=%b, want %h %b %b", k, i, seg, an, cout, seg_m, an_m, cout_m);
        end
      end
    end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_enable();
    test_load_at_advance();
    test_reset_midscan();
    test_leading_blank();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
